// File: rtl/instr_mem_pkg.sv
// ---------------------------------------------------------------------------
// instr_mem_pkg
// Shared types and default constants for the instruction memory / fetch
// engine slice.
//   DATA_W_DEF, DEPTH_DEF, ADDR_W_DEF : default geometry
//   fetch_entry_t                     : one buffered fetch result
//                                       {instr, addr, err} at default geometry
// ---------------------------------------------------------------------------
package instr_mem_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int DEPTH_DEF     = 64;
  localparam int ADDR_W_DEF    = $clog2(DEPTH_DEF);
  localparam int BUF_DEPTH_DEF = 2;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] instr;
    logic [ADDR_W_DEF-1:0] addr;
    logic                  err;
  } fetch_entry_t;

endpackage

// File: rtl/instr_mem_fetch_buf.sv
// ---------------------------------------------------------------------------
// fetch_buf
// Small synchronous FIFO holding fetched instructions between the memory
// read and the consumer handshake.
//   clk, reset_n : clock, asynchronous active-low reset
//   flush        : drop every entry (wins over push/pop)
//   push         : write push_data at the tail (caller guarantees room)
//   push_data    : entry to store
//   pop          : remove the head entry (caller guarantees non-empty)
//   head_data    : current head entry, zero while empty
//   head_valid   : buffer holds at least one entry
//   count        : number of entries held, 0..DEPTH
// ---------------------------------------------------------------------------
module fetch_buf #(
  parameter  int WIDTH = 39,
  parameter  int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             head_valid,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] entries [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) entries[wr_ptr] <= push_data;
  end

  // Storage is not reset, so the head is forced to zero while empty.
  assign head_valid = (count != '0);
  assign head_data  = head_valid ? entries[rd_ptr] : '0;

endmodule

// File: rtl/instr_mem_fetch.sv
// ---------------------------------------------------------------------------
// instr_mem_fetch
// Instruction memory with an integrated sequential fetch engine. A program
// counter walks the memory one word per cycle into a small output buffer
// which is drained through a valid/ready handshake. A redirect port flushes
// the buffer and reloads the PC; a store port writes the program and stalls
// fetching for that cycle.
//
// Optional feature macro: INSTR_MEM_PARITY_EN
//   defined   : every word carries an even-parity bit, re-checked on fetch,
//               mismatches flagged on instr_err
//   undefined : no parity storage, instr_err tied to 0
//
// Ports:
//   clk, reset_n          : clock, asynchronous active-low reset
//   store_en/addr/data    : program load port (priority over fetch)
//   fetch_en              : allow sequential fetching
//   redirect_valid/addr   : flush buffer and jump to redirect_addr
//   instr_valid/ready     : head handshake
//   instr, instr_addr     : head instruction and its word address
//   instr_err             : parity error on the head entry
// ---------------------------------------------------------------------------
module instr_mem_fetch
  import instr_mem_pkg::*;
#(
  parameter  int DATA_W     = DATA_W_DEF,
  parameter  int DEPTH      = DEPTH_DEF,
  parameter  int BUF_DEPTH  = BUF_DEPTH_DEF,
  parameter  int RESET_ADDR = 0,
  localparam int ADDR_W     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              store_en,
  input  logic [ADDR_W-1:0] store_addr,
  input  logic [DATA_W-1:0] store_data,
  input  logic              fetch_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_addr,
  output logic              instr_err
);

  localparam int ENTRY_W = DATA_W + ADDR_W + 1;
  localparam int CNT_W   = $clog2(BUF_DEPTH) + 1;

  logic [DATA_W-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0]  pc;
  logic [CNT_W-1:0]   buf_count;
  logic [CNT_W-1:0]   occ_after_pop;
  logic [ENTRY_W-1:0] push_data;
  logic [ENTRY_W-1:0] head_data;
  logic               pop;
  logic               issue;
  logic               read_err;

  always_ff @(posedge clk) begin
    if (store_en) mem[store_addr] <= store_data;
  end

`ifdef INSTR_MEM_PARITY_EN
  logic par_mem [DEPTH];

  // Even parity: stored bit equals XOR of the data, so a clean word
  // always re-checks to zero.
  always_ff @(posedge clk) begin
    if (store_en) par_mem[store_addr] <= ^store_data;
  end

  assign read_err = (^mem[pc]) ^ par_mem[pc];
`else
  assign read_err = 1'b0;
`endif

  assign pop = instr_valid && instr_ready;

  // Room is judged after this cycle's pop, so a full buffer being drained
  // can still accept a new word every cycle.
  assign occ_after_pop = buf_count - CNT_W'(pop);
  assign issue = fetch_en && !store_en && !redirect_valid &&
                 (occ_after_pop < CNT_W'(BUF_DEPTH));

  assign push_data = {mem[pc], pc, read_err};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= ADDR_W'(RESET_ADDR);
    end else if (redirect_valid) begin
      pc <= redirect_addr;
    end else if (issue) begin
      pc <= pc + ADDR_W'(1);
    end
  end

  fetch_buf #(
    .WIDTH (ENTRY_W),
    .DEPTH (BUF_DEPTH)
  ) u_fetch_buf (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (redirect_valid),
    .push       (issue),
    .push_data  (push_data),
    .pop        (pop),
    .head_data  (head_data),
    .head_valid (instr_valid),
    .count      (buf_count)
  );

  assign instr      = head_data[ENTRY_W-1 -: DATA_W];
  assign instr_addr = head_data[ADDR_W:1];
  assign instr_err  = head_data[0];

endmodule

// File: tb/tb_instr_mem_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_mem_fetch
// Self-checking bench for instr_mem_fetch: directed vector table, parity
// corruption sequence (when INSTR_MEM_PARITY_EN is defined), mid-operation
// reset, and randomized traffic checked against a queue-based model.
// ---------------------------------------------------------------------------
module tb_instr_mem_fetch;
  import instr_mem_pkg::*;

  localparam int DW    = 32;
  localparam int DEP   = 64;
  localparam int AW    = 6;
  localparam int BDEP  = 2;

  typedef struct {
    logic          st;
    logic [AW-1:0] sa;
    logic [DW-1:0] sd;
    logic          fe;
    logic          rd;
    logic [AW-1:0] ra;
    logic          rdy;
    logic          ev;
    logic [AW-1:0] ea;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          store_en;
  logic [AW-1:0] store_addr;
  logic [DW-1:0] store_data;
  logic          fetch_en;
  logic          redirect_valid;
  logic [AW-1:0] redirect_addr;
  logic          instr_valid;
  logic          instr_ready;
  logic [DW-1:0] instr;
  logic [AW-1:0] instr_addr;
  logic          instr_err;

  int tests_run = 0;
  int tests_failed = 0;

  logic [DW-1:0] mem_m [DEP];
  bit            corrupt_m [DEP];
  int            pc_m;
  fetch_entry_t  q_m [$];

  vec_t tbl [32];

  always #5 clk = ~clk;

  instr_mem_fetch #(
    .DATA_W     (DW),
    .DEPTH      (DEP),
    .BUF_DEPTH  (BDEP),
    .RESET_ADDR (0)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .store_en       (store_en),
    .store_addr     (store_addr),
    .store_data     (store_data),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_addr     (instr_addr),
    .instr_err      (instr_err)
  );

  function automatic vec_t mk(logic fe, logic rdy, logic rd, logic [AW-1:0] ra,
                              logic st, logic [AW-1:0] sa, logic [DW-1:0] sd,
                              logic ev, logic [AW-1:0] ea);
    vec_t v;
    v.fe = fe; v.rdy = rdy; v.rd = rd; v.ra = ra;
    v.st = st; v.sa = sa; v.sd = sd; v.ev = ev; v.ea = ea;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: one clock edge worth of the fetch rules on a queue.
  task automatic modelStep(input vec_t s);
    int           occ;
    bit           pop, issue;
    fetch_entry_t e;
    occ   = q_m.size();
    pop   = (occ > 0) && s.rdy;
    issue = s.fe && !s.st && !s.rd && ((occ - int'(pop)) < BDEP);
    e.instr = mem_m[pc_m];
    e.addr  = AW'(pc_m);
    e.err   = corrupt_m[pc_m];
    if (s.st) begin
      mem_m[s.sa]     = s.sd;
      corrupt_m[s.sa] = 1'b0;
    end
    if (s.rd) begin
      q_m.delete();
      pc_m = int'(s.ra);
    end else begin
      if (pop) void'(q_m.pop_front());
      if (issue) begin
        q_m.push_back(e);
        pc_m = (pc_m + 1) % DEP;
      end
    end
  endtask

  task automatic checkOutput(input string tag);
    cmp({tag, "_valid"}, 64'(instr_valid), 64'(q_m.size() > 0));
    if (q_m.size() > 0) begin
      cmp({tag, "_instr"}, 64'(instr), 64'(q_m[0].instr));
      cmp({tag, "_addr"},  64'(instr_addr), 64'(q_m[0].addr));
      cmp({tag, "_err"},   64'(instr_err), 64'(q_m[0].err));
    end
  endtask

  // Called at a negedge: drive, advance model, clock once, check at negedge.
  task automatic applyStimulus(input vec_t s, input string tag);
    store_en       = s.st;
    store_addr     = s.sa;
    store_data     = s.sd;
    fetch_en       = s.fe;
    redirect_valid = s.rd;
    redirect_addr  = s.ra;
    instr_ready    = s.rdy;
    modelStep(s);
    @(posedge clk);
    @(negedge clk);
    checkOutput(tag);
  endtask

  initial begin
    vec_t s;
    reset_n        = 1'b0;
    store_en       = 1'b0;
    store_addr     = '0;
    store_data     = '0;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    instr_ready    = 1'b0;
    pc_m           = 0;
    for (int i = 0; i < DEP; i++) begin
      mem_m[i]     = '0;
      corrupt_m[i] = 1'b0;
    end

    repeat (2) @(negedge clk);
    cmp("reset_valid", 64'(instr_valid), 64'd0);
    cmp("reset_instr", 64'(instr), 64'd0);
    cmp("reset_addr",  64'(instr_addr), 64'd0);
    cmp("reset_err",   64'(instr_err), 64'd0);
    reset_n = 1'b1;

    // Program load: mem[i] = 0x1000_0000 + i with fetch disabled.
    for (int i = 0; i < DEP; i++) begin
      s = mk(1'b0, 1'b1, 1'b0, '0, 1'b1, AW'(i), 32'h1000_0000 + DW'(i), 1'b0, '0);
      applyStimulus(s, "load");
    end

    // Directed table: {fe, rdy, redirect, raddr, store, saddr, sdata, exp_valid, exp_addr}
    for (int i = 0; i < 8; i++)
      tbl[i] = mk(1, 1, 0, '0, 0, '0, '0, 1, AW'(i));
    tbl[8] = mk(1, 1, 1, 6'd0, 0, '0, '0, 0, '0);
    for (int i = 9; i < 14; i++)
      tbl[i] = mk(1, 0, 0, '0, 0, '0, '0, 1, 6'd0);
    tbl[14] = mk(1, 1, 0, '0, 0, '0, '0, 1, 6'd1);
    tbl[15] = mk(1, 1, 0, '0, 0, '0, '0, 1, 6'd2);
    tbl[16] = mk(1, 0, 0, '0, 0, '0, '0, 1, 6'd2);
    tbl[17] = mk(1, 1, 1, 6'h20, 0, '0, '0, 0, '0);
    tbl[18] = mk(1, 1, 0, '0, 0, '0, '0, 1, 6'h20);
    tbl[19] = mk(1, 1, 0, '0, 0, '0, '0, 1, 6'h21);
    tbl[20] = mk(1, 1, 1, 6'd63, 0, '0, '0, 0, '0);
    tbl[21] = mk(1, 1, 0, '0, 0, '0, '0, 1, 6'd63);
    tbl[22] = mk(1, 1, 0, '0, 0, '0, '0, 1, 6'd0);
    tbl[23] = mk(1, 1, 0, '0, 0, '0, '0, 1, 6'd1);
    tbl[24] = mk(1, 1, 1, 6'd5, 0, '0, '0, 0, '0);
    tbl[25] = mk(1, 1, 0, '0, 1, 6'd5, 32'hABCD_0005, 0, '0);
    tbl[26] = mk(1, 1, 0, '0, 0, '0, '0, 1, 6'd5);
    tbl[27] = mk(1, 1, 0, '0, 0, '0, '0, 1, 6'd6);
    tbl[28] = mk(0, 1, 0, '0, 0, '0, '0, 0, '0);
    tbl[29] = mk(0, 1, 0, '0, 0, '0, '0, 0, '0);
    tbl[30] = mk(1, 1, 1, 6'h10, 1, 6'h10, 32'h5555_AAAA, 0, '0);
    tbl[31] = mk(1, 1, 0, '0, 0, '0, '0, 1, 6'h10);

    for (int i = 0; i < 32; i++) begin
      applyStimulus(tbl[i], $sformatf("tbl%0d", i));
      cmp($sformatf("tbl%0d_exp_valid", i), 64'(instr_valid), 64'(tbl[i].ev));
      if (tbl[i].ev) cmp($sformatf("tbl%0d_exp_addr", i), 64'(instr_addr), 64'(tbl[i].ea));
    end
    cmp("store_new_data", 64'(mem_m[5]), 64'h0000_0000_ABCD_0005);

`ifdef INSTR_MEM_PARITY_EN
    // Flip one stored data bit behind the parity bit's back.
    dut.mem[3] = dut.mem[3] ^ 32'h0000_0001;
    mem_m[3]     = mem_m[3] ^ 32'h0000_0001;
    corrupt_m[3] = 1'b1;
    applyStimulus(mk(1, 1, 1, 6'd0, 0, '0, '0, 0, '0), "par_redir");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(mk(1, 1, 0, '0, 0, '0, '0, 0, '0), "par");
      cmp($sformatf("par_err_addr%0d", i), 64'(instr_err), 64'(i == 3));
    end
`endif

    // Reset mid-operation with entries buffered.
    applyStimulus(mk(1, 0, 1, 6'd9, 0, '0, '0, 0, '0), "pre_rst");
    applyStimulus(mk(1, 0, 0, '0, 0, '0, '0, 0, '0), "pre_rst");
    applyStimulus(mk(1, 0, 0, '0, 0, '0, '0, 0, '0), "pre_rst");
    reset_n = 1'b0;
    #1;
    cmp("midrst_valid", 64'(instr_valid), 64'd0);
    cmp("midrst_instr", 64'(instr), 64'd0);
    cmp("midrst_addr",  64'(instr_addr), 64'd0);
    cmp("midrst_err",   64'(instr_err), 64'd0);
    q_m.delete();
    pc_m = 0;
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(mk(1, 1, 0, '0, 0, '0, '0, 1, 6'd0), "post_rst");
    cmp("post_rst_addr", 64'(instr_addr), 64'd0);

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      s.st  = ($urandom % 8) == 0;
      s.sa  = AW'($urandom);
      s.sd  = $urandom;
      s.fe  = ($urandom % 4) != 0;
      s.rd  = ($urandom % 16) == 0;
      s.ra  = AW'($urandom);
      s.rdy = ($urandom % 3) != 0;
      s.ev  = 1'b0;
      s.ea  = '0;
      applyStimulus(s, "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
